jtag_ahb_master: RTL and testbench

- AHB-Lite single-transfer master driven by the JTAG AHB data register path.
- Accepts one command (address, write data, direction, size) latched at DR update, runs one AHB-Lite NONSEQ transfer, and returns read data plus status for the next DR capture.
- It is the bus-side counterpart of the JTAG AHB register.
- Sits between the TAP data-register logic and the SoC AHB-Lite fabric; single clock domain.

---
 rtl/jtag_ahb_master.sv | 196 +++++++++++++++++++
 tb/tb_jtag_ahb_master.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/jtag_ahb_master.sv
// Single-transfer AHB-Lite master behind the JTAG AHB data register.
// A command is latched from the DR update. The master then runs one NONSEQ
// transfer and holds the read data and status for the next DR capture.
//
// Ports:
//   TCK, TRST           clock and asynchronous active-high reset
//   cmd_*               command from the DR update; cmd_valid is a one-cycle pulse
//   status_clear        clears the sticky flags, the response and wait_cnt
//   busy, rsp_*         transfer status and returned read data
//   overrun             sticky flag: a command arrived while busy
//   wait_cnt            HREADY-low cycles of the last transfer (saturating)
//   H*                  AHB-Lite master interface
module jtag_ahb_master #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              TCK,
    input  logic              TRST,
    input  logic              cmd_valid,
    input  logic              cmd_write,
    input  logic [2:0]        cmd_size,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic              status_clear,
    output logic              busy,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              overrun,
    output logic [7:0]        wait_cnt,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    localparam int unsigned WAIT_W = 8;
    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(255);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   haddr_q, haddr_d;
    logic [DATA_W-1:0]   hwdata_q, hwdata_d;
    logic                hwrite_q, hwrite_d;
    logic [2:0]          hsize_q, hsize_d;
    logic [1:0]          htrans_q, htrans_d;
    logic                busy_q, busy_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic                overrun_q, overrun_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;

    logic                cmd_legal;
    logic [WAIT_W-1:0]   wait_base;
    logic [WAIT_W-1:0]   wait_inc;

    // The size must be at most a word, and the address must be aligned to it.
    always_comb begin
        case (cmd_size)
            3'd0:    cmd_legal = 1'b1;
            3'd1:    cmd_legal = (cmd_addr[0] == 1'b0);
            3'd2:    cmd_legal = (cmd_addr[1:0] == 2'b00);
            default: cmd_legal = 1'b0;
        endcase
    end

    // A clear in the same cycle as a wait zeroes the old count first.
    assign wait_base = status_clear ? '0 : wait_cnt_q;
    assign wait_inc  = (wait_base == WAIT_MAX) ? wait_base : wait_base + WAIT_W'(1);

    // Next state, command latching and status update.
    always_comb begin
        state_d     = state_q;
        haddr_d     = haddr_q;
        hwdata_d    = hwdata_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        overrun_d   = overrun_q;
        rsp_rdata_d = rsp_rdata_q;
        wait_cnt_d  = wait_base;

        if (status_clear) begin
            rsp_valid_d = 1'b0;
            rsp_err_d   = 1'b0;
            overrun_d   = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_legal) begin
                        state_d     = ST_ADDR;
                        haddr_d     = cmd_addr;
                        hwdata_d    = cmd_wdata;
                        hwrite_d    = cmd_write;
                        hsize_d     = cmd_size;
                        wait_cnt_d  = '0;
                        rsp_valid_d = 1'b0;
                        rsp_err_d   = 1'b0;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (cmd_valid) begin
                    overrun_d = 1'b1;
                end
                if (HREADY) begin
                    state_d = ST_DATA;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end
            ST_DATA: begin
                if (cmd_valid) begin
                    overrun_d = 1'b1;
                end
                if (!HREADY) begin
                    wait_cnt_d = wait_inc;
                end else begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = HRESP;
                    if (!hwrite_q && !HRESP) begin
                        rsp_rdata_d = HRDATA;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        htrans_d = (state_d == ST_ADDR) ? TRANS_NONSEQ : TRANS_IDLE;
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            state_q     <= ST_IDLE;
            haddr_q     <= '0;
            hwdata_q    <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= '0;
            htrans_q    <= TRANS_IDLE;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
            rsp_rdata_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            haddr_q     <= haddr_d;
            hwdata_q    <= hwdata_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            htrans_q    <= htrans_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            overrun_q   <= overrun_d;
            rsp_rdata_q <= rsp_rdata_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign overrun   = overrun_q;
    assign wait_cnt  = wait_cnt_q;
    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HBURST    = 3'b000;
    assign HWDATA    = hwdata_q;

endmodule

// File: tb/tb_jtag_ahb_master.sv
// Directed bench for jtag_ahb_master. The expected values are worked out by hand.
module tb_jtag_ahb_master;

    logic        TCK = 1'b0;
    logic        TRST;
    logic        cmd_valid, cmd_write, status_clear;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        busy, rsp_valid, rsp_err, overrun;
    logic [31:0] rsp_rdata;
    logic [7:0]  wait_cnt;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;

    int checks   = 0;
    int failures = 0;

    jtag_ahb_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .TCK(TCK), .TRST(TRST),
        .cmd_valid(cmd_valid), .cmd_write(cmd_write), .cmd_size(cmd_size),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .status_clear(status_clear),
        .busy(busy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .overrun(overrun), .wait_cnt(wait_cnt),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 TCK = ~TCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle; all driving and sampling happens 1ns after posedge.
    task automatic tick();
        @(posedge TCK);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [2:0] sz,
                         input logic [31:0] addr, input logic [31:0] wd);
        cmd_valid = 1'b1; cmd_write = wr; cmd_size = sz;
        cmd_addr = addr; cmd_wdata = wd;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        TRST = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 3'd0;
        cmd_addr = '0; cmd_wdata = '0; status_clear = 1'b0;
        HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        #23;
        check("rst_htrans", 32'(HTRANS), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_flags", 32'({rsp_valid, rsp_err, overrun}), 32'h0);
        check("rst_haddr", HADDR, 32'h0);
        check("rst_wait", 32'(wait_cnt), 32'h0);
        TRST = 1'b0;
        tick();

        // Read with zero wait states.
        HRDATA = 32'hDEAD_BEEF;
        issue(1'b0, 3'd2, 32'h0000_1004, 32'h0);
        check("rd_htrans_addr", 32'(HTRANS), 32'h2);
        check("rd_haddr", HADDR, 32'h0000_1004);
        check("rd_hsize", 32'(HSIZE), 32'h2);
        check("rd_hwrite", 32'(HWRITE), 32'h0);
        check("rd_hburst", 32'(HBURST), 32'h0);
        check("rd_busy1", 32'(busy), 32'h1);
        tick();
        check("rd_htrans_data", 32'(HTRANS), 32'h0);
        check("rd_busy2", 32'(busy), 32'h1);
        tick();
        check("rd_busy_done", 32'(busy), 32'h0);
        check("rd_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check("rd_flags", 32'({rsp_valid, rsp_err}), 32'h2);
        check("rd_wait", 32'(wait_cnt), 32'h0);

        // Write with three wait states in the data phase.
        issue(1'b1, 3'd2, 32'h20, 32'h1234_5678);
        check("wr_valid_cleared", 32'(rsp_valid), 32'h0);
        check("wr_hwrite", 32'(HWRITE), 32'h1);
        tick();
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wr_hwdata_held", HWDATA, 32'h1234_5678);
            check("wr_busy_wait", 32'(busy), 32'h1);
        end
        HREADY = 1'b1;
        tick();
        check("wr_busy_done", 32'(busy), 32'h0);
        check("wr_wait", 32'(wait_cnt), 32'h3);
        check("wr_flags", 32'({rsp_valid, rsp_err}), 32'h2);
        check("wr_rdata_kept", rsp_rdata, 32'hDEAD_BEEF);

        // Read that gets a two-cycle error response.
        HRDATA = 32'h5555_5555;
        issue(1'b0, 3'd2, 32'h40, 32'h0);
        tick();
        HRESP = 1'b1; HREADY = 1'b0;
        tick();
        check("err_wait_cycle", 32'(wait_cnt), 32'h1);
        HREADY = 1'b1;
        tick();
        HRESP = 1'b0;
        check("err_flags", 32'({rsp_valid, rsp_err}), 32'h3);
        check("err_rdata_kept", rsp_rdata, 32'hDEAD_BEEF);
        check("err_wait", 32'(wait_cnt), 32'h1);
        check("err_busy", 32'(busy), 32'h0);

        // Illegal commands.
        status_clear = 1'b1; tick(); status_clear = 1'b0;
        check("clr_flags", 32'({rsp_valid, rsp_err}), 32'h0);
        check("clr_wait", 32'(wait_cnt), 32'h0);
        issue(1'b0, 3'd2, 32'h2, 32'h0);
        check("ill_misalign_htrans", 32'(HTRANS), 32'h0);
        check("ill_misalign_flags", 32'({rsp_valid, rsp_err}), 32'h3);
        check("ill_misalign_busy", 32'(busy), 32'h0);
        status_clear = 1'b1; tick(); status_clear = 1'b0;
        issue(1'b0, 3'd3, 32'h0, 32'h0);
        check("ill_size_htrans", 32'(HTRANS), 32'h0);
        check("ill_size_flags", 32'({rsp_valid, rsp_err}), 32'h3);
        check("ill_rdata_kept", rsp_rdata, 32'hDEAD_BEEF);
        tick();
        check("ill_stay_idle", 32'(HTRANS), 32'h0);

        // A command arriving during the data-phase wait sets overrun.
        HRDATA = 32'hCAFE_0001;
        issue(1'b0, 3'd2, 32'h80, 32'h0);
        tick();
        HREADY = 1'b0;
        tick();
        issue(1'b1, 3'd2, 32'h99, 32'hFFFF_FFFF);
        check("ovr_flag", 32'(overrun), 32'h1);
        check("ovr_haddr", HADDR, 32'h80);
        check("ovr_busy", 32'(busy), 32'h1);
        HREADY = 1'b1;
        tick();
        check("ovr_rdata", rsp_rdata, 32'hCAFE_0001);
        check("ovr_done_flags", 32'({rsp_valid, rsp_err, overrun}), 32'h5);
        check("ovr_wait", 32'(wait_cnt), 32'h2);
        tick();
        check("ovr_no_second_xfer", 32'(HTRANS), 32'h0);
        status_clear = 1'b1; tick(); status_clear = 1'b0;
        check("ovr_clr_flags", 32'({rsp_valid, rsp_err, overrun}), 32'h0);
        check("ovr_clr_wait", 32'(wait_cnt), 32'h0);

        // Reset asserted in the address phase while HREADY is low.
        HREADY = 1'b0;
        issue(1'b0, 3'd2, 32'h100, 32'h0);
        tick();
        check("trst_pre_htrans", 32'(HTRANS), 32'h2);
        TRST = 1'b1;
        #1;
        check("trst_htrans", 32'(HTRANS), 32'h0);
        check("trst_busy", 32'(busy), 32'h0);
        #1;
        TRST = 1'b0;
        HREADY = 1'b1;
        tick();
        HRDATA = 32'h0BAD_F00D;
        issue(1'b0, 3'd1, 32'h106, 32'h0);
        check("post_haddr", HADDR, 32'h106);
        check("post_hsize", 32'(HSIZE), 32'h1);
        tick();
        tick();
        check("post_rdata", rsp_rdata, 32'h0BAD_F00D);
        check("post_flags", 32'({busy, rsp_valid, rsp_err}), 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
